// File: rtl/aes_encipher_round_engine_if.sv
// aes_encipher_round_engine_if: host, key-memory and S-box signals of the AES encipher round engine.
//   next/keylen/block    : start pulse, key length code, plaintext
//   ready/new_block      : idle flag, ciphertext
//   round/round_key      : round-key index to the key memory, its read data in the same cycle
//   sboxw/new_sboxw      : word sent to the shared S-box, substituted word in the same cycle
// The slave modport is the engine; the master modport is the surrounding system.
interface aes_encipher_round_engine_if;
    logic         next;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] new_block;
    logic         ready;
    modport master(output next, keylen, block, round_key, new_sboxw,
                   input round, sboxw, new_block, ready);
    modport slave(input next, keylen, block, round_key, new_sboxw,
                  output round, sboxw, new_block, ready);
endinterface

// File: rtl/aes_encipher_round_engine.sv
// aes_encipher_round_engine: iterative AES-128/192/256 encryption datapath, one S-box word per cycle.
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   abort_i   : drop the current operation (only when AES_ENC_ABORT_EN is defined)
//   eng_if    : slave side of aes_encipher_round_engine_if (host handshake, key memory, S-box)
// Optional feature macro: AES_ENC_ABORT_EN.
module aes_encipher_round_engine #(
    parameter int NUM_SBOX_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
`ifdef AES_ENC_ABORT_EN
    input  logic abort_i,
`endif
    aes_encipher_round_engine_if.slave eng_if
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] SBOX = 2'd2;
    localparam logic [1:0] MAIN = 2'd3;

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [1:0]   keylen_q, keylen_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   word_ctr_q, word_ctr_d;
    logic         ready_q, ready_d;
    logic [127:0] new_block_q, new_block_d;
    logic [3:0]   nr;
    logic [127:0] sr, shifted;
    logic [31:0]  cur_word;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Byte (row k, column c) sits at bits 127-32c-8k; row k rotates left by k columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[127-32*c-8*k -: 8] = s[127-32*((c+k)%4)-8*k -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return r;
    endfunction

    assign nr       = keylen_q == 2'd0 ? 4'd10 : keylen_q == 2'd2 ? 4'd12 : 4'd14;
    assign sr       = shift_rows(blk_q);
    assign shifted  = blk_q << {word_ctr_q, 5'd0};
    assign cur_word = shifted[127:96];

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        keylen_d    = keylen_q;
        round_ctr_d = round_ctr_q;
        word_ctr_d  = word_ctr_q;
        ready_d     = ready_q;
        new_block_d = new_block_q;
        case (fsm_q)
            IDLE: begin
                if (eng_if.next && eng_if.keylen != 2'd3) begin
                    keylen_d = eng_if.keylen;
                    blk_d    = eng_if.block;
                    ready_d  = 1'b0;
                    fsm_d    = INIT;
                end
            end
            INIT: begin
                blk_d       = blk_q ^ eng_if.round_key;
                round_ctr_d = 4'd1;
                word_ctr_d  = 2'd0;
                fsm_d       = SBOX;
            end
            SBOX: begin
                for (int c = 0; c < 4; c++)
                    if (word_ctr_q == 2'(c))
                        blk_d[127-32*c -: 32] = eng_if.new_sboxw;
                word_ctr_d = word_ctr_q + 2'd1;
                fsm_d      = word_ctr_q == 2'(NUM_SBOX_CYCLES - 1) ? MAIN : SBOX;
            end
            MAIN: begin
                if (round_ctr_q < nr) begin
                    blk_d       = mix_columns(sr) ^ eng_if.round_key;
                    round_ctr_d = round_ctr_q + 4'd1;
                    fsm_d       = SBOX;
                end else begin
                    blk_d       = sr ^ eng_if.round_key;
                    new_block_d = sr ^ eng_if.round_key;
                    ready_d     = 1'b1;
                    round_ctr_d = 4'd0;
                    fsm_d       = IDLE;
                end
            end
        endcase
`ifdef AES_ENC_ABORT_EN
        if (abort_i && fsm_q != IDLE) begin
            fsm_d       = IDLE;
            ready_d     = 1'b1;
            new_block_d = '0;
            round_ctr_d = 4'd0;
            word_ctr_d  = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            keylen_q    <= 2'd0;
            round_ctr_q <= 4'd0;
            word_ctr_q  <= 2'd0;
            ready_q     <= 1'b1;
            new_block_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            keylen_q    <= keylen_d;
            round_ctr_q <= round_ctr_d;
            word_ctr_q  <= word_ctr_d;
            ready_q     <= ready_d;
            new_block_q <= new_block_d;
        end
    end

    // round_ctr is 0 in IDLE and INIT, so the key index needs no state decode.
    assign eng_if.round     = round_ctr_q;
    assign eng_if.sboxw     = fsm_q == SBOX ? cur_word : 32'd0;
    assign eng_if.new_block = new_block_q;
    assign eng_if.ready     = ready_q;
endmodule

// File: tb/tb_aes_encipher_round_engine.sv
// tb_aes_encipher_round_engine: FIPS-197 vector bench with key-memory and S-box models.
module tb_aes_encipher_round_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
`ifdef AES_ENC_ABORT_EN
    logic abort = 1'b0;
`endif
    aes_encipher_round_engine_if bus();

    aes_encipher_round_engine dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef AES_ENC_ABORT_EN
        .abort_i(abort),
`endif
        .eng_if(bus)
    );

    always #5 clk = ~clk;

    logic [7:0]   sbox_t [256];
    logic [127:0] rks [16];
    int           hist [16];
    int           passed = 0;
    int           total = 0;

    assign bus.round_key = rks[bus.round];
    assign bus.new_sboxw = {sbox_t[bus.sboxw[31:24]], sbox_t[bus.sboxw[23:16]],
                            sbox_t[bus.sboxw[15:8]], sbox_t[bus.sboxw[7:0]]};

    typedef struct {
        logic [1:0]   kl;
        logic [127:0] blk;
        logic [127:0] exp;
        int           lat;
    } vec_t;
    vec_t vecs [3];

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gm(inv, 8'(x));
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_keys(input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl == 2'd0 ? 4 : kl == 2'd2 ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run(input logic [1:0] kl, input logic [127:0] blk, input bit disturb, output int lat);
        load_keys(kl);
        for (int i = 0; i < 16; i++) hist[i] = 0;
        bus.keylen = kl;
        bus.block = blk;
        bus.next = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!bus.ready && lat < 200) begin
            hist[bus.round]++;
            bus.next = disturb && lat == 10;
            if (disturb && lat == 10) begin
                bus.block = ~blk;
                bus.keylen = 2'd1;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.next = 1'b0;
    endtask

    initial begin
        int lat, nr, n;
        bit ok;
        logic [127:0] held;
        vecs[0] = '{2'd0, PT, C1, 51};
        vecs[1] = '{2'd2, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 61};
        vecs[2] = '{2'd1, PT, 128'h8ea2b7ca516745bfeafc49904b496089, 71};
        bus.next = 1'b0;
        bus.keylen = 2'd0;
        bus.block = '0;
        build_sbox();
        load_keys(2'd0);
        #12;
        check("reset_ready", 128'(bus.ready), 128'd1);
        check("reset_new_block", bus.new_block, 128'd0);
        check("reset_round", 128'(bus.round), 128'd0);
        check("reset_sboxw", 128'(bus.sboxw), 128'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            run(vecs[v].kl, vecs[v].blk, 1'b0, lat);
            check($sformatf("latency_%0d", v), 128'(lat), 128'(vecs[v].lat));
            check($sformatf("new_block_%0d", v), bus.new_block, vecs[v].exp);
            nr = (vecs[v].lat - 1) / 5;
            ok = hist[0] == 1;
            for (int r = 1; r < 16; r++) ok &= hist[r] == (r <= nr ? 5 : 0);
            check($sformatf("round_seq_%0d", v), 128'(ok), 128'd1);
        end
        check("idle_round", 128'(bus.round), 128'd0);

        run(2'd0, PT, 1'b1, lat);
        check("disturb_latency", 128'(lat), 128'd51);
        check("disturb_new_block", bus.new_block, C1);

        held = bus.new_block;
        bus.keylen = 2'd3;
        bus.next = 1'b1;
        @(posedge clk); #1;
        bus.next = 1'b0;
        check("kl3_ready", 128'(bus.ready), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check("kl3_idle", {bus.ready, bus.round, bus.sboxw}, {1'b1, 4'd0, 32'd0});
        check("kl3_new_block", bus.new_block, held);

        load_keys(2'd0);
        bus.keylen = 2'd0;
        bus.block = PT;
        bus.next = 1'b1;
        @(posedge clk); #1;
        bus.next = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("busy_before_reset", 128'(bus.ready), 128'd0);
        reset_n = 1'b0;
        #1;
        check("async_reset", {bus.ready, bus.round, bus.new_block}, {1'b1, 4'd0, 128'd0});
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run(2'd0, PT, 1'b0, lat);
        check("post_reset_latency", 128'(lat), 128'd51);
        check("post_reset_new_block", bus.new_block, C1);

`ifdef AES_ENC_ABORT_EN
        load_keys(2'd0);
        bus.next = 1'b1;
        @(posedge clk); #1;
        bus.next = 1'b0;
        n = 0;
        while (bus.round != 4'd5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached_round5", 128'(bus.round), 128'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", {bus.ready, bus.round, bus.new_block}, {1'b1, 4'd0, 128'd0});
        run(2'd0, PT, 1'b0, lat);
        check("post_abort_latency", 128'(lat), 128'd51);
        check("post_abort_new_block", bus.new_block, C1);
`else
        n = 0;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_encipher_round_engine.md
Name: aes_encipher_round_engine

Overview:
- Iterative AES encryption datapath that consumes round keys from the key memory through the index/data read port: drives `round`, samples `round_key` combinationally.
- Shares the external 32-bit S-box through the same `sboxw`/`new_sboxw` word interface the key memory uses. External arbitration grants the S-box to whichever block is busy.
- Supports AES-128/192/256 with the same `keylen` encoding as the key memory.

Parameters:
- NUM_SBOX_CYCLES, 4, S-box words processed per round, one per cycle; fixed at 4, other values unsupported.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- next  in  1  start pulse, sampled only in IDLE
- keylen  in  2  0=AES-128 (10 rounds), 2=AES-192 (12), 1=AES-256 (14), 3=reserved
- block  in  128  plaintext, bits 127:96 = state column 0
- round  out  4  round-key index driven to key memory
- round_key  in  128  key-memory read data for `round`, same cycle
- sboxw  out  32  word to substitute
- new_sboxw  in  32  substituted word, same cycle
- new_block  out  128  ciphertext
- ready  out  1  high when idle and new_block valid

Behaviour:
- Reset values: ready=1, new_block=0, round=0, sboxw=0; FSM=IDLE, round_ctr=0, word_ctr=0, keylen latch=0.
- FSM states are IDLE, INIT, SBOX, MAIN.
- IDLE:
  - `next`=1 with keylen≠3: latch keylen and block, clear ready, go to INIT.
  - `next`=1 with keylen=3: ignored; stay in IDLE, ready unchanged.
- INIT (1 cycle):
  - round=0; state ← block ^ round_key.
  - round_ctr ← 1, word_ctr ← 0; go to SBOX.
- SBOX (4 cycles):
  - sboxw = state word[word_ctr], word 0 = bits 127:96.
  - State word[word_ctr] ← new_sboxw; word_ctr increments, wrapping 3→0.
  - After word 3, go to MAIN.
- MAIN (1 cycle), with round = round_ctr:
  - round_ctr < Nr: state ← MixColumns(ShiftRows(state)) ^ round_key; round_ctr++; go to SBOX.
  - round_ctr == Nr: state ← ShiftRows(state) ^ round_key; new_block ← state; ready ← 1; go to IDLE.
- Arithmetic follows FIPS-197:
  - ShiftRows rotates row r left by r columns.
  - MixColumns works in GF(2^8) with reduction polynomial 0x11b; xtime = {b[6:0],0} ^ (0x1b & {8{b[7]}}).
- Latency: ready is low for exactly 1+5·Nr cycles after the edge that samples `next`, i.e. 51 (AES-128), 61 (AES-192) or 71 (AES-256). ready rises on the following edge.
- `round` is driven from round_ctr in every state and reads 0 in IDLE. sboxw is 0 outside SBOX.
- new_block holds its value until the next completion; it is not cleared at start.
- `next` while busy is ignored. Changes to keylen or block while busy have no effect, since both are latched.
- Back-to-back operation: `next` sampled in the first IDLE cycle after ready rises starts immediately.
- reset_n low at any time: all state returns asynchronously to reset values, so the current operation is lost and ready=1.
- round_key must be stable for the whole INIT/MAIN cycle. The engine never reads round indices above Nr.

Optional Feature:
- Macro AES_ENC_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in INIT, SBOX or MAIN: next state is IDLE, ready ← 1, new_block ← 0, round_ctr ← 0, word_ctr ← 0.
  - `abort` in IDLE has no effect, and it takes priority over `next` in the same cycle.
- When undefined: no `abort` port; behaviour as above.

Test Plan:
- AES-128 FIPS-197 C.1: key 000102…0f, block 00112233445566778899aabbccddeeff, next → after 51 busy cycles ready=1, new_block=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192 C.2: key 000102…17, same block → 61 busy cycles, new_block=dda97ca4864cdfe06eaf70a0ec0d7191.
- AES-256 C.3: key 000102…1f, same block → 71 busy cycles, new_block=8ea2b7ca516745bfeafc49904b496089; `round` sequence observed 0,1,…,14 once each at INIT/MAIN.
- Robustness: pulse `next` and change block mid-operation (AES-128 vector) → result still 69c4e0d8…c55a, latency still 51. keylen=3 with next → ready stays 1, FSM stays IDLE, new_block unchanged.
- Reset in the 20th busy cycle → ready=1, new_block=0, round=0 immediately; a fresh C.1 run then completes correctly.
- With AES_ENC_ABORT_EN: abort during SBOX of round 5 → next cycle ready=1, new_block=0; a subsequent C.1 run produces 69c4e0d8…c55a.
